// File: rtl/syn_sram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// syn_sram_arbiter_pkg
//
// Purpose:
//   Shared types and defaults for the external SRAM arbiter. The arbiter FSM
//   state and the agent identifiers live here so that the VGA line fetcher and
//   the testbench can use the same names.
//
// Contents:
//   C_*            default parameter values used by the interface and the top
//   sram_arb_fsm_t arbiter FSM state (IDLE, ACCESS, TURN)
//   sram_agent_t   access owner (AGENT_VGA = agent 0, AGENT_GPU = agent 1)
//   lane_n()       active-low byte-lane enables for one access
// -----------------------------------------------------------------------------
package syn_sram_arbiter_pkg;

    localparam int unsigned C_ADDR_W       = 18;
    localparam int unsigned C_DATA_W       = 16;
    localparam int unsigned C_ACC_CYCLES   = 2;
    localparam int unsigned C_MAX_HP_BURST = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TURN   = 2'd2
    } sram_arb_fsm_t;

    typedef enum logic {
        AGENT_VGA = 1'b0,
        AGENT_GPU = 1'b1
    } sram_agent_t;

    // Reads always use both lanes; writes enable only the requested bytes.
    // Result is {ub_n, lb_n}.
    function automatic logic [1:0] lane_n(input logic i_wr, input logic [1:0] i_be);
        return i_wr ? ~i_be : 2'b00;
    endfunction

endpackage

// File: rtl/syn_sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// syn_sram_arbiter_if
//
// Purpose:
//   Bundles the two requester ports and the SRAM pin signals of the arbiter.
//
// Handshake (both agents):
//   A requester raises aN_req_i with its address (and, for agent 1, wr, wdata
//   and be) and holds all of them stable until the one-cycle aN_ack_o pulse.
//   The arbiter does not look at the request in the cycle after ack, so the
//   requester may drop it or present the next request from that cycle on.
//   Read data comes back later as a one-cycle aN_rd_valid_o pulse with
//   aN_rdata_o, which then holds until the next pulse. Writes return nothing.
//
// Modports:
//   slave  - the arbiter side (requests and SRAM read data in, rest out)
//   master - the environment side (requesters plus the SRAM device)
//
// Debug:
//   dbg_state_o exposes the arbiter FSM state.
// -----------------------------------------------------------------------------
interface syn_sram_arbiter_if
    import syn_sram_arbiter_pkg::*;
#(
    parameter int unsigned P_ADDR_W = C_ADDR_W,
    parameter int unsigned P_DATA_W = C_DATA_W
) ();

    // Agent 0: VGA line fetcher, read only
    logic                a0_req_i;
    logic [P_ADDR_W-1:0] a0_addr_i;
    logic                a0_ack_o;
    logic                a0_rd_valid_o;
    logic [P_DATA_W-1:0] a0_rdata_o;

    // Agent 1: pixel/GPU port, read and write
    logic                a1_req_i;
    logic                a1_wr_i;
    logic [P_ADDR_W-1:0] a1_addr_i;
    logic [P_DATA_W-1:0] a1_wdata_i;
    logic [1:0]          a1_be_i;
    logic                a1_ack_o;
    logic                a1_rd_valid_o;
    logic [P_DATA_W-1:0] a1_rdata_o;

    // SRAM pins
    logic [P_ADDR_W-1:0] sram_addr_o;
    logic [P_DATA_W-1:0] sram_do_o;
    logic [P_DATA_W-1:0] sram_di_i;
    logic                sram_ce_n_o;
    logic                sram_oe_n_o;
    logic                sram_we_n_o;
    logic                sram_lb_n_o;
    logic                sram_ub_n_o;

    // Debug
    sram_arb_fsm_t       dbg_state_o;

    modport slave (
        input  a0_req_i, a0_addr_i,
        output a0_ack_o, a0_rd_valid_o, a0_rdata_o,
        input  a1_req_i, a1_wr_i, a1_addr_i, a1_wdata_i, a1_be_i,
        output a1_ack_o, a1_rd_valid_o, a1_rdata_o,
        output sram_addr_o, sram_do_o,
        input  sram_di_i,
        output sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_lb_n_o, sram_ub_n_o,
        output dbg_state_o
    );

    modport master (
        output a0_req_i, a0_addr_i,
        input  a0_ack_o, a0_rd_valid_o, a0_rdata_o,
        output a1_req_i, a1_wr_i, a1_addr_i, a1_wdata_i, a1_be_i,
        input  a1_ack_o, a1_rd_valid_o, a1_rdata_o,
        input  sram_addr_o, sram_do_o,
        output sram_di_i,
        input  sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_lb_n_o, sram_ub_n_o,
        input  dbg_state_o
    );

endinterface

// File: rtl/syn_sram_arbiter.sv
// -----------------------------------------------------------------------------
// syn_sram_arbiter
//
// Purpose:
//   Shares one external 16-bit asynchronous SRAM between the VGA line fetcher
//   (agent 0, read only, high priority) and the pixel/GPU port (agent 1, read
//   and write, low priority). Every access runs for P_ACC_CYCLES clocks, is
//   followed by at least one idle cycle with all controls deasserted, and a
//   write that follows a read gets one extra turnaround cycle. Agent 1 is
//   guaranteed a slot after P_MAX_HP_BURST consecutive agent-0 grants.
//
// Ports:
//   clk_ir  - cortex clock
//   rst_ih  - synchronous active-high reset
//   bus     - syn_sram_arbiter_if.slave: both requester ports, SRAM pins and
//             the FSM state debug output
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module syn_sram_arbiter
    import syn_sram_arbiter_pkg::*;
#(
    parameter int unsigned P_ADDR_W       = C_ADDR_W,
    parameter int unsigned P_DATA_W       = C_DATA_W,
    parameter int unsigned P_ACC_CYCLES   = C_ACC_CYCLES,   // 1..7
    parameter int unsigned P_MAX_HP_BURST = C_MAX_HP_BURST
) (
    input  logic              clk_ir,
    input  logic              rst_ih,
    syn_sram_arbiter_if.slave bus
);

    localparam int unsigned LP_CNT_W = (P_MAX_HP_BURST < 1) ? 1 : $clog2(P_MAX_HP_BURST + 1);
    localparam int unsigned LP_ACC_W = 3;
    localparam logic [LP_CNT_W-1:0] LP_CNT_MAX  = LP_CNT_W'(P_MAX_HP_BURST);
    localparam logic [LP_ACC_W-1:0] LP_ACC_LAST = LP_ACC_W'(P_ACC_CYCLES - 1);

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    sram_arb_fsm_t       r_state;
    sram_agent_t         r_owner;      // agent that owns the current access
    logic                r_is_wr;      // current access is a write
    logic                r_last_rd;    // most recent access was a read
    logic [LP_ACC_W-1:0] r_acc_cnt;    // ACCESS cycles left after this one
    logic [LP_CNT_W-1:0] r_starve;     // agent-0 grants while agent 1 waits

    logic                r_a0_ack;
    logic                r_a0_rd_valid;
    logic [P_DATA_W-1:0] r_a0_rdata;
    logic                r_a1_ack;
    logic                r_a1_rd_valid;
    logic [P_DATA_W-1:0] r_a1_rdata;

    logic [P_ADDR_W-1:0] r_sram_addr;
    logic [P_DATA_W-1:0] r_sram_do;
    logic                r_sram_ce_n;
    logic                r_sram_oe_n;
    logic                r_sram_we_n;
    logic                r_sram_lb_n;
    logic                r_sram_ub_n;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic                w_starved;
    logic                w_a1_win;
    logic                w_any_req;
    logic                w_need_turn;
    logic                w_go_access;
    sram_agent_t         w_sel_agent;
    logic                w_sel_wr;
    logic [P_ADDR_W-1:0] w_sel_addr;
    logic [1:0]          w_sel_lanes_n;

    // Agent 1 only overrides agent 0 once the burst allowance is used up.
    assign w_starved   = bus.a1_req_i && (r_starve == LP_CNT_MAX);
    assign w_a1_win    = bus.a1_req_i && (!bus.a0_req_i || w_starved);
    assign w_any_req   = bus.a0_req_i || bus.a1_req_i;
    // Give the data bus one cycle to settle before driving it after a read.
    assign w_need_turn = w_a1_win && bus.a1_wr_i && r_last_rd;

    // TURN is only ever entered for an agent-1 write, whose fields the
    // requester keeps stable until ack, so they are taken from the port here.
    assign w_go_access = (r_state == TURN) ||
                         ((r_state == IDLE) && w_any_req && !w_need_turn);

    assign w_sel_agent   = ((r_state == TURN) || w_a1_win) ? AGENT_GPU : AGENT_VGA;
    assign w_sel_wr      = (w_sel_agent == AGENT_GPU) && bus.a1_wr_i;
    assign w_sel_addr    = (w_sel_agent == AGENT_GPU) ? bus.a1_addr_i : bus.a0_addr_i;
    assign w_sel_lanes_n = (w_sel_agent == AGENT_GPU) ? lane_n(bus.a1_wr_i, bus.a1_be_i)
                                                      : 2'b00;

    // -------------------------------------------------------------------------
    // FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_ir) begin
        if (rst_ih) begin
            r_state       <= IDLE;
            r_owner       <= AGENT_VGA;
            r_is_wr       <= 1'b0;
            r_last_rd     <= 1'b0;
            r_acc_cnt     <= '0;
            r_starve      <= '0;
            r_a0_ack      <= 1'b0;
            r_a0_rd_valid <= 1'b0;
            r_a0_rdata    <= '0;
            r_a1_ack      <= 1'b0;
            r_a1_rd_valid <= 1'b0;
            r_a1_rdata    <= '0;
            r_sram_addr   <= '0;
            r_sram_do     <= '0;
            r_sram_ce_n   <= 1'b1;
            r_sram_oe_n   <= 1'b1;
            r_sram_we_n   <= 1'b1;
            r_sram_lb_n   <= 1'b1;
            r_sram_ub_n   <= 1'b1;
        end else begin
            // Acks and read-valids are single-cycle pulses.
            r_a0_ack      <= 1'b0;
            r_a1_ack      <= 1'b0;
            r_a0_rd_valid <= 1'b0;
            r_a1_rd_valid <= 1'b0;

            unique case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state <= w_need_turn ? TURN : ACCESS;
                    end
                end

                TURN: begin
                    // Controls are already deasserted from the IDLE cycle.
                    r_state <= ACCESS;
                end

                ACCESS: begin
                    if (r_acc_cnt == '0) begin
                        // Release the controls; address and data stay put for
                        // one more cycle, which is the write hold time.
                        r_state     <= IDLE;
                        r_sram_ce_n <= 1'b1;
                        r_sram_oe_n <= 1'b1;
                        r_sram_we_n <= 1'b1;
                        r_sram_lb_n <= 1'b1;
                        r_sram_ub_n <= 1'b1;
                        if (!r_is_wr) begin
                            if (r_owner == AGENT_VGA) begin
                                r_a0_rd_valid <= 1'b1;
                                r_a0_rdata    <= bus.sram_di_i;
                            end else begin
                                r_a1_rd_valid <= 1'b1;
                                r_a1_rdata    <= bus.sram_di_i;
                            end
                        end
                    end else begin
                        r_acc_cnt <= r_acc_cnt - LP_ACC_W'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase

            // Start of an access: ack the winner and drive the SRAM.
            if (w_go_access) begin
                r_a0_ack    <= (w_sel_agent == AGENT_VGA);
                r_a1_ack    <= (w_sel_agent == AGENT_GPU);
                r_owner     <= w_sel_agent;
                r_is_wr     <= w_sel_wr;
                r_last_rd   <= !w_sel_wr;
                r_acc_cnt   <= LP_ACC_LAST;
                r_sram_addr <= w_sel_addr;
                if (w_sel_wr) begin
                    r_sram_do <= bus.a1_wdata_i;
                end
                r_sram_ce_n <= 1'b0;
                r_sram_oe_n <= w_sel_wr;
                r_sram_we_n <= !w_sel_wr;
                r_sram_ub_n <= w_sel_lanes_n[1];
                r_sram_lb_n <= w_sel_lanes_n[0];
            end

            // Starvation counter: cleared whenever agent 1 is not waiting,
            // otherwise it counts agent-0 wins up to the burst limit.
            if (!bus.a1_req_i) begin
                r_starve <= '0;
            end else if (r_state == IDLE) begin
                if (w_a1_win) begin
                    r_starve <= '0;
                end else if (bus.a0_req_i && (r_starve != LP_CNT_MAX)) begin
                    r_starve <= r_starve + LP_CNT_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.a0_ack_o      = r_a0_ack;
    assign bus.a0_rd_valid_o = r_a0_rd_valid;
    assign bus.a0_rdata_o    = r_a0_rdata;
    assign bus.a1_ack_o      = r_a1_ack;
    assign bus.a1_rd_valid_o = r_a1_rd_valid;
    assign bus.a1_rdata_o    = r_a1_rdata;
    assign bus.sram_addr_o   = r_sram_addr;
    assign bus.sram_do_o     = r_sram_do;
    assign bus.sram_ce_n_o   = r_sram_ce_n;
    assign bus.sram_oe_n_o   = r_sram_oe_n;
    assign bus.sram_we_n_o   = r_sram_we_n;
    assign bus.sram_lb_n_o   = r_sram_lb_n;
    assign bus.sram_ub_n_o   = r_sram_ub_n;
    assign bus.dbg_state_o   = r_state;

endmodule

// File: tb/tb_syn_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_syn_sram_arbiter
//
// Bench for syn_sram_arbiter: a behavioural async SRAM, a table of agent-1
// transactions, and hand-written sequences for single read, contention,
// back-to-back reads and reset in the middle of an access.
// -----------------------------------------------------------------------------
module tb_syn_sram_arbiter;
    import syn_sram_arbiter_pkg::*;

    localparam int unsigned AW   = 18;
    localparam int unsigned DW   = 16;
    localparam int unsigned ACC  = 2;
    localparam int unsigned MAXB = 4;

    // ------------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    syn_sram_arbiter_if #(.P_ADDR_W(AW), .P_DATA_W(DW)) sif ();

    syn_sram_arbiter #(
        .P_ADDR_W      (AW),
        .P_DATA_W      (DW),
        .P_ACC_CYCLES  (ACC),
        .P_MAX_HP_BURST(MAXB)
    ) dut (
        .clk_ir(clk),
        .rst_ih(rst),
        .bus   (sif.slave)
    );

    // ------------------------------------------------------------------ counters
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ SRAM model
    logic [DW-1:0] mem [0:(1<<AW)-1];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a == 18'h00010) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = init_val(AW'(i));
    end

    assign sif.sram_di_i = (!sif.sram_ce_n_o && !sif.sram_oe_n_o) ? mem[sif.sram_addr_o] : 16'h0000;

    always @(negedge clk) begin
        if (!sif.sram_ce_n_o && !sif.sram_we_n_o) begin
            if (!sif.sram_lb_n_o) mem[sif.sram_addr_o][7:0]  = sif.sram_do_o[7:0];
            if (!sif.sram_ub_n_o) mem[sif.sram_addr_o][15:8] = sif.sram_do_o[15:8];
        end
    end

    // ------------------------------------------------------------------ scoreboard / monitor
    logic [DW-1:0] exp_a0_q[$];
    logic [DW-1:0] exp_a1_q[$];
    int ce_run   = 0;
    int ce_gap   = 0;
    int last_gap = 0;
    int n_rdv0   = 0;
    int n_rdv1   = 0;

    always @(negedge clk) begin
        if (rst) begin
            ce_run = 0;
            ce_gap = 0;
        end else begin
            if (!sif.sram_ce_n_o) begin
                if (ce_run == 0) last_gap = ce_gap;
                ce_run++;
                ce_gap = 0;
            end else begin
                if (ce_run != 0) check("acc_len", 32'(ce_run), 32'(ACC));
                ce_run = 0;
                ce_gap++;
                check("idle_ctrl_high",
                      32'({sif.sram_oe_n_o, sif.sram_we_n_o, sif.sram_ub_n_o, sif.sram_lb_n_o}),
                      32'h0000000F);
            end
            if (sif.a0_rd_valid_o) begin
                n_rdv0++;
                n_checks++;
                if (exp_a0_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL a0_rdv_unexpected: got rd_valid with data 0x%0h, expected none", sif.a0_rdata_o);
                end else begin
                    n_checks--;
                    check("a0_rdata", 32'(sif.a0_rdata_o), 32'(exp_a0_q.pop_front()));
                end
            end
            if (sif.a1_rd_valid_o) begin
                n_rdv1++;
                n_checks++;
                if (exp_a1_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL a1_rdv_unexpected: got rd_valid with data 0x%0h, expected none", sif.a1_rdata_o);
                end else begin
                    n_checks--;
                    check("a1_rdata", 32'(sif.a1_rdata_o), 32'(exp_a1_q.pop_front()));
                end
            end
        end
    end

    // ------------------------------------------------------------------ driver tasks
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit agent, output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if ((agent ? sif.a1_ack_o : sif.a0_ack_o) == 1'b1) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic wait_rdv(input bit agent, output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if ((agent ? sif.a1_rd_valid_o : sif.a0_rd_valid_o) == 1'b1) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_a0_q.size() == 0 && exp_a1_q.size() == 0) return;
            step();
        end
        check("drain_timeout", 32'(exp_a0_q.size() + exp_a1_q.size()), 32'd0);
    endtask

    // ------------------------------------------------------------------ vectors
    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    be;
        logic [DW-1:0] exp_rdata;
        logic [1:0]    exp_lanes_n;   // {ub_n, lb_n}
        int            exp_gap;       // idle cycles before this access
    } vec_t;

    vec_t vecs [9];
    int   exp_seq [10];

    initial begin
        int lat;
        int got;
        int rdv_before;

        vecs[0] = '{1'b1, 18'h3FFFF, 16'h12AB, 2'b01, 16'h0000, 2'b10, 0};
        vecs[1] = '{1'b0, 18'h3FFFF, 16'h0000, 2'b11, 16'hA5AB, 2'b00, 1};
        vecs[2] = '{1'b1, 18'h00100, 16'hCAFE, 2'b10, 16'h0000, 2'b01, 2};
        vecs[3] = '{1'b0, 18'h00100, 16'h0000, 2'b11, 16'hCA5A, 2'b00, 1};
        vecs[4] = '{1'b1, 18'h00101, 16'h1234, 2'b11, 16'h0000, 2'b00, 2};
        vecs[5] = '{1'b0, 18'h00101, 16'h0000, 2'b11, 16'h1234, 2'b00, 1};
        vecs[6] = '{1'b1, 18'h00102, 16'hFFFF, 2'b00, 16'h0000, 2'b11, 2};
        vecs[7] = '{1'b0, 18'h00102, 16'h0000, 2'b11, 16'h5B58, 2'b00, 1};
        vecs[8] = '{1'b0, 18'h00010, 16'h0000, 2'b11, 16'hBEEF, 2'b00, 1};
        exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        sif.a0_req_i   = 1'b0;
        sif.a0_addr_i  = '0;
        sif.a1_req_i   = 1'b0;
        sif.a1_wr_i    = 1'b0;
        sif.a1_addr_i  = '0;
        sif.a1_wdata_i = '0;
        sif.a1_be_i    = 2'b00;

        // ---------------- reset state
        rst = 1'b1;
        repeat (3) step();
        check("rst_pulses", 32'({sif.a0_ack_o, sif.a1_ack_o, sif.a0_rd_valid_o, sif.a1_rd_valid_o}), 32'd0);
        check("rst_rdata", 32'({sif.a0_rdata_o, sif.a1_rdata_o}), 32'd0);
        check("rst_addr", 32'(sif.sram_addr_o), 32'd0);
        check("rst_do", 32'(sif.sram_do_o), 32'd0);
        check("rst_ctrl", 32'({sif.sram_ce_n_o, sif.sram_oe_n_o, sif.sram_we_n_o,
                               sif.sram_ub_n_o, sif.sram_lb_n_o}), 32'h1F);
        rst = 1'b0;
        repeat (2) step();

        // ---------------- single read
        sif.a0_req_i  = 1'b1;
        sif.a0_addr_i = 18'h00010;
        exp_a0_q.push_back(16'hBEEF);
        wait_ack(1'b0, lat);
        check("rd_ack_latency", 32'(lat), 32'd1);
        check("rd_ctrl", 32'({sif.sram_ce_n_o, sif.sram_oe_n_o, sif.sram_we_n_o,
                              sif.sram_ub_n_o, sif.sram_lb_n_o}), 32'h04);
        check("rd_addr", 32'(sif.sram_addr_o), 32'h10);
        sif.a0_req_i = 1'b0;
        wait_rdv(1'b0, lat);
        check("rd_valid_latency", 32'(lat), 32'(ACC));
        repeat (3) step();
        check("rdata_hold", 32'(sif.a0_rdata_o), 32'hBEEF);
        check("rdv_single_pulse", 32'(sif.a0_rd_valid_o), 32'd0);

        // ---------------- agent-1 table (byte writes, turnaround)
        for (int i = 0; i < 9; i++) begin
            sif.a1_req_i   = 1'b1;
            sif.a1_wr_i    = vecs[i].wr;
            sif.a1_addr_i  = vecs[i].addr;
            sif.a1_wdata_i = vecs[i].wdata;
            sif.a1_be_i    = vecs[i].be;
            if (!vecs[i].wr) exp_a1_q.push_back(vecs[i].exp_rdata);
            wait_ack(1'b1, lat);
            check("vec_ack_seen", 32'(lat > 0), 32'd1);
            check("vec_ctrl", 32'({sif.sram_ce_n_o, sif.sram_oe_n_o, sif.sram_we_n_o}),
                  vecs[i].wr ? 32'h2 : 32'h1);
            check("vec_lanes", 32'({sif.sram_ub_n_o, sif.sram_lb_n_o}), 32'(vecs[i].exp_lanes_n));
            check("vec_addr", 32'(sif.sram_addr_o), 32'(vecs[i].addr));
            if (vecs[i].wr) check("vec_do", 32'(sif.sram_do_o), 32'(vecs[i].wdata));
            if (i > 0) check("vec_gap", 32'(last_gap), 32'(vecs[i].exp_gap));
            sif.a1_req_i = 1'b0;
        end
        drain();
        check("mem_low_byte", 32'(mem[18'h3FFFF]), 32'hA5AB);
        check("mem_be00", 32'(mem[18'h00102]), 32'h5B58);

        // ---------------- contention
        repeat (2) step();
        sif.a0_req_i  = 1'b1;
        sif.a0_addr_i = 18'h00020;
        sif.a1_req_i  = 1'b1;
        sif.a1_wr_i   = 1'b0;
        sif.a1_addr_i = 18'h00030;
        sif.a1_be_i   = 2'b11;
        for (int g = 0; g < 10; g++) begin
            got = -1;
            for (int c = 0; c < 40 && got < 0; c++) begin
                step();
                if (sif.a0_ack_o) got = 0;
                else if (sif.a1_ack_o) got = 1;
            end
            if (got == 0) exp_a0_q.push_back(init_val(18'h00020));
            if (got == 1) exp_a1_q.push_back(init_val(18'h00030));
            check("grant_seq", 32'(got), 32'(exp_seq[g]));
        end
        sif.a0_req_i = 1'b0;
        sif.a1_req_i = 1'b0;
        drain();

        // ---------------- back-to-back agent-0 reads 0..7
        repeat (2) step();
        rdv_before    = n_rdv0;
        sif.a0_req_i  = 1'b1;
        sif.a0_addr_i = '0;
        for (int k = 0; k < 8; k++) begin
            exp_a0_q.push_back(init_val(AW'(k)));
            wait_ack(1'b0, lat);
            check(k == 0 ? "b2b_first_ack" : "b2b_ack_spacing", 32'(lat), k == 0 ? 32'd1 : 32'(ACC + 1));
            sif.a0_addr_i = AW'(k + 1);
        end
        sif.a0_req_i = 1'b0;
        drain();
        check("b2b_rdv_count", 32'(n_rdv0 - rdv_before), 32'd8);

        // ---------------- reset mid-access
        repeat (2) step();
        rdv_before    = n_rdv0;
        sif.a0_req_i  = 1'b1;
        sif.a0_addr_i = 18'h00011;
        wait_ack(1'b0, lat);
        check("rst_mid_ack", 32'(lat), 32'd1);
        sif.a0_req_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_ctrl", 32'({sif.sram_ce_n_o, sif.sram_oe_n_o, sif.sram_we_n_o,
                                   sif.sram_ub_n_o, sif.sram_lb_n_o}), 32'h1F);
        check("rst_mid_pulses", 32'({sif.a0_ack_o, sif.a0_rd_valid_o}), 32'd0);
        repeat (6) step();
        check("rst_mid_no_rdv", 32'(n_rdv0 - rdv_before), 32'd0);
        sif.a0_req_i  = 1'b1;
        sif.a0_addr_i = 18'h00007;
        exp_a0_q.push_back(init_val(18'h00007));
        wait_ack(1'b0, lat);
        check("post_rst_ack", 32'(lat), 32'd1);
        sif.a0_req_i = 1'b0;
        wait_rdv(1'b0, lat);
        check("post_rst_rdv", 32'(lat), 32'(ACC));

        // ---------------- report
        drain();
        repeat (3) step();
        check("queues_empty", 32'(exp_a0_q.size() + exp_a1_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, expected test to finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/syn_sram_arbiter.md
Name: syn_sram_arbiter

Overview:
- Shares the single external 16-bit asynchronous SRAM between two requesters inside cortex.
- Agent 0 is the VGA line fetcher: read-only, high priority.
- Agent 1 is the pixel/GPU port: read and write, low priority.
- The block sequences each SRAM access through a fixed-length cycle, enforces bus turnaround, and drives the SRAM pin signals that the FPGA top ties to SRAM_*.

Parameters:
- P_ADDR_W, 18: SRAM word address width.
- P_DATA_W, 16: SRAM data width.
- P_ACC_CYCLES, 2: clock cycles per SRAM access (legal range 1..7).
- P_MAX_HP_BURST, 4: consecutive agent-0 grants allowed while agent 1 waits.

Ports:
- clk_ir  in  1  cortex clock, 50 MHz.
- rst_ih  in  1  synchronous active-high reset.
- a0_req_i  in  1  agent-0 read request.
- a0_addr_i  in  P_ADDR_W  agent-0 address.
- a0_ack_o  out  1  agent-0 grant pulse.
- a0_rd_valid_o  out  1  agent-0 read data valid.
- a0_rdata_o  out  P_DATA_W  agent-0 read data.
- a1_req_i  in  1  agent-1 request.
- a1_wr_i  in  1  1=write, 0=read.
- a1_addr_i  in  P_ADDR_W  agent-1 address.
- a1_wdata_i  in  P_DATA_W  agent-1 write data.
- a1_be_i  in  2  byte enables; [1]=upper, [0]=lower.
- a1_ack_o  out  1  agent-1 grant pulse.
- a1_rd_valid_o  out  1  agent-1 read data valid.
- a1_rdata_o  out  P_DATA_W  agent-1 read data.
- sram_addr_o  out  P_ADDR_W  to SRAM_ADDR.
- sram_do_o  out  P_DATA_W  write data; the top drives SRAM_DQ from it when SRAM_WE_N=0.
- sram_di_i  in  P_DATA_W  from SRAM_DQ.
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_lb_n_o, sram_ub_n_o  out  1 each  SRAM controls, active low.

Behaviour:
- Interface basics: one clock (clk_ir); reset is synchronous and active-high (rst_ih).
- All outputs are registered.
- Reset values:
  - ack, rd_valid and rdata outputs: 0.
  - sram_addr_o, sram_do_o: 0.
  - sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_lb_n_o, sram_ub_n_o: 1.
  - FSM state: IDLE; starvation counter: 0.
- FSM states: IDLE, ACCESS, TURN.
- IDLE:
  - Samples requests. Agent 0 wins unless a1_req_i=1 and the starvation counter equals P_MAX_HP_BURST; in that case agent 1 wins.
  - Granting agent 0 increments the counter, saturating at P_MAX_HP_BURST, but only while a1_req_i=1.
  - Granting agent 1, or any cycle with a1_req_i=0, clears the counter.
  - If the winner is an agent-1 write and the previous access was a read, go to TURN. Otherwise go to ACCESS.
- TURN: one cycle with all controls deasserted; then ACCESS.
- Entering ACCESS (cycle t+1, where t is the IDLE decision cycle):
  - Winner's ack pulses high for exactly one cycle.
  - Address, data and byte lanes are latched; sram_ce_n_o=0.
  - Read: sram_oe_n_o=0, lb/ub=0, we=1.
  - Write: sram_we_n_o=0, oe=1, lb_n/ub_n = ~a1_be_i.
  - Agent-0 accesses always use both lanes.
- ACCESS lasts P_ACC_CYCLES cycles. sram_addr_o and sram_do_o stay constant throughout.
- On the last ACCESS cycle, a read captures sram_di_i at the clock edge. The next cycle returns to IDLE with the owner's rd_valid_o=1 for one cycle and rdata updated.
- Exiting ACCESS:
  - ce, oe, we, lb and ub all return to 1.
  - Address and data are held, so write hold time is one cycle.
- Throughput: one access per P_ACC_CYCLES+1 cycles (+1 for a read-to-write turnaround). Read latency, ack to rd_valid: P_ACC_CYCLES cycles.
- Requester rule: hold req and its fields stable until ack. The arbiter ignores req in the cycle after ack, because it is in ACCESS. A requester may present a new request from that cycle on.
- rdata holds its value between rd_valid pulses.
- A write produces no rd_valid.
- Reset asserted mid-access: outputs return to reset values on the next edge, the pending rd_valid is discarded, and no ack is issued.
- a1_be_i=2'b00 on a write still consumes an access slot, with lb_n=ub_n=1 and WE pulsing.

Decomposition:
- Add to syn_global_pkg:
  - typedef enum sram_arb_fsm_t {IDLE, ACCESS, TURN};
  - typedef enum sram_agent_t {AGENT_VGA, AGENT_GPU}.
- Agent register naming is shared with the VGA fetcher.
- No sub-module is needed. The priority/starvation logic stays inline, about 200 lines in total.

Test Plan:
- Single read: a0_req at addr 0x00010 with the SRAM model returning 0xBEEF, P_ACC_CYCLES=2 → ack at t+1, oe_n low for 2 cycles, a0_rd_valid at t+3 with rdata 0xBEEF.
- Byte write: a1 write addr 0x3FFFF, data 0x12AB, be=2'b01 → lb_n=0, ub_n=1, we_n low for 2 cycles; the model updates only the low byte to 0xAB.
- Contention: both requesters held continuously, P_MAX_HP_BURST=4 → grant sequence 0,0,0,0,1,0,0,0,0,1.
- Turnaround: a1 read then a1 write back-to-back → exactly one TURN cycle with all controls high between the two accesses.
- Reset mid-access: rst_ih pulsed during cycle 1 of a read → next cycle all controls 1, no rd_valid ever emitted, next request served normally.
- Back-to-back a0 reads to 0..7 → one ack every 3 cycles, 8 rd_valid pulses with data in order.
